// File: rtl/avg_ram_ctrl_if.sv
// avg_ram_ctrl_if: FIFO-side and RAM-side signals of the averaging controller.
interface avg_ram_ctrl_if #(parameter int DATA_W = 8, parameter int ADDR_W = 10);
  logic enable;
  logic clr;
  logic wrap_en;
  logic fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic rd_fifo;
  logic zero_sel;
  logic ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic ram_full;
  logic busy;
  modport master (
    input enable, clr, wrap_en, fifo_empty, fifo_data,
    output rd_fifo, zero_sel, ram_wr, ram_addr, ram_data, ram_full, busy
  );
  modport slave (
    output enable, clr, wrap_en, fifo_empty, fifo_data,
    input rd_fifo, zero_sel, ram_wr, ram_addr, ram_data, ram_full, busy
  );
endinterface

// File: rtl/avg_ram_ctrl.sv
// avg_ram_ctrl: drains a FIFO, averages groups of 2**LOG2_N samples, writes each average to sequential RAM addresses.
// Define AVG_ROUND_EN for round-half-up averages; truncation otherwise.
module avg_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2,
  parameter int ADDR_W = 10
) (
  input logic clk_50,
  input logic reset_n,
  avg_ram_ctrl_if.master bus
);
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] LAST = (LOG2_N + 1)'(2 ** LOG2_N - 1);
  typedef enum logic [2:0] {IDLE, READ, ACC, WRITE, FULL} state_t;
  state_t state, state_nx;
  logic [LOG2_N:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ADDR_W-1:0] addr;
  logic full;
  logic go, last, top, stop;
  logic [DATA_W-1:0] avg;
  assign go = bus.enable && !bus.fifo_empty;
  assign last = cnt == LAST;
  assign top = &addr;
  assign stop = top && !bus.wrap_en;
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = go && !full ? READ : IDLE;
      READ: state_nx = ACC;
      ACC: state_nx = last ? WRITE : go ? READ : IDLE;
      WRITE: state_nx = stop ? FULL : go ? READ : IDLE;
      default: state_nx = FULL;
    endcase
    if (bus.clr) state_nx = IDLE;
  end
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n || bus.clr) begin
      cnt <= '0;
      acc <= '0;
      addr <= '0;
      full <= 1'b0;
    end else begin
      if (state == ACC) begin
        acc <= cnt == '0 ? ACC_W'(bus.fifo_data) : acc + ACC_W'(bus.fifo_data);
        cnt <= last ? '0 : cnt + (LOG2_N + 1)'(1);
      end
      if (state == WRITE) begin
        if (stop) full <= 1'b1;
        else addr <= addr + ADDR_W'(1);
      end
    end
`ifdef AVG_ROUND_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + (ACC_W + 1)'((2 ** LOG2_N) / 2);
  assign avg = DATA_W'(sum >> LOG2_N);
`else
  assign avg = DATA_W'(acc >> LOG2_N);
`endif
  assign bus.rd_fifo = state == READ;
  assign bus.zero_sel = state == ACC && cnt == '0;
  assign bus.ram_wr = state == WRITE;
  assign bus.ram_addr = addr;
  assign bus.ram_data = state == WRITE ? avg : '0;
  assign bus.ram_full = full;
  assign bus.busy = state inside {READ, ACC, WRITE};
endmodule

// File: doc/avg_ram_ctrl.md
# avg_ram_ctrl

Parametrised FIFO-to-RAM averaging controller. It drains samples from an upstream FIFO and accumulates groups of 2**LOG2_N samples. Each completed average is written to the next sequential RAM address. It sits between the sample FIFO and the result RAM in the clk_50 domain, replacing the fixed four-byte control-only sequencer with a version that integrates the accumulator datapath and supports configurable group size, address wrap and rounding.

## Interface
- DATA_W, 8: sample and average width.
- LOG2_N, 2: log2 of samples per average; legal values 0..6.
- ADDR_W, 10: RAM address width.

- clk_50  in  1  clock; all logic is rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permits new FIFO reads.
- clr  in  1  synchronous clear; highest priority after reset.
- wrap_en  in  1  1: address wraps to 0 after the top address; 0: block stops at the top address.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after rd_fifo.
- rd_fifo  out  1  one-cycle FIFO pop strobe.
- zero_sel  out  1  high in the cycle where the accumulator loads rather than adds (first sample of a group).
- ram_wr  out  1  one-cycle RAM write strobe.
- ram_addr  out  ADDR_W  write address.
- ram_data  out  DATA_W  average value.
- ram_full  out  1  sticky flag: top address written with wrap_en=0.
- busy  out  1  high in any state other than IDLE and FULL.

## Operation
- The FSM has five states: IDLE, READ, ACC, WRITE, FULL.
- **IDLE**
  - Goes to READ when enable && !fifo_empty && !ram_full.
- **READ**
  - rd_fifo=1.
  - Always goes to ACC.
- **ACC**
  - Captures fifo_data.
  - If cnt==0: zero_sel=1 and acc loads fifo_data. Otherwise acc adds fifo_data.
  - Next state:
    - WRITE if cnt==2**LOG2_N-1.
    - Else READ if enable && !fifo_empty.
    - Else IDLE.
  - cnt increments, modulo 2**LOG2_N.
- **WRITE**
  - ram_wr=1; ram_addr and ram_data are stable.
  - If ram_addr==2**ADDR_W-1:
    - wrap_en=1: ram_addr returns to 0.
    - wrap_en=0: ram_full is set and the next state is FULL.
  - Otherwise ram_addr increments.
  - Next state (when not going to FULL):
    - READ if enable && !fifo_empty.
    - Else IDLE.
- **FULL**
  - No reads or writes.
  - Left only via clr or reset.
- Arithmetic:
  - acc is DATA_W+LOG2_N bits wide and cannot overflow.
  - ram_data = acc >> LOG2_N, computed combinationally from acc during WRITE.
- When enable falls mid-group, the in-flight READ→ACC completes. The partial group and cnt are retained in IDLE and resume when enable returns.
- A partial group is never written.
- wrap_en is sampled only in WRITE.
- clr (synchronous) forces IDLE and sets cnt=0, acc=0, ram_addr=0, ram_full=0. The partial group is discarded. If clr coincides with READ, the popped sample is lost by design.
- Reset values: state IDLE, every output 0, cnt=0, acc=0.

## Timing
- Each sample takes 2 cycles (READ, ACC).
- A group takes 2·2**LOG2_N + 1 cycles with a non-empty FIFO.
- With LOG2_N=2 and a non-empty FIFO: rd_fifo pulses at cycles 0, 2, 4, 6 and ram_wr pulses at cycle 8. The next rd_fifo is at cycle 9.
- ram_wr and the ram_addr increment take effect together: the write uses the old address, and the new address is visible the following cycle.
- fifo_empty is sampled only in IDLE, ACC and WRITE. It is never sampled in the cycle rd_fifo is high.
- Reset deasserted mid-group restarts cleanly from IDLE with no spurious rd_fifo or ram_wr.

## Configuration
- AVG_ROUND_EN
  - Defined: ram_data = (acc + 2**(LOG2_N-1)) >> LOG2_N, i.e. round-half-up. The sum uses DATA_W+LOG2_N+1 bits. The result provably fits in DATA_W. For LOG2_N=0 the adder term is 0.
  - Undefined: truncation, ram_data = acc >> LOG2_N.

## Test plan
- Samples 10, 20, 30, 40, with defaults:
  - ram_wr once, ram_addr=0, ram_data=25.
  - zero_sel high only in the ACC cycle of sample 10.
  - rd_fifo/ram_wr spacing matches the 9-cycle sequence above.
- Samples 1, 2, 2, 2 (sum 7):
  - ram_data=1 without AVG_ROUND_EN.
  - ram_data=2 with AVG_ROUND_EN.
  - Samples 255×4 give 255 in both builds.
- ADDR_W=2, five groups:
  - wrap_en=1: writes to addresses 0, 1, 2, 3, 0.
  - wrap_en=0: ram_full=1 after the write to address 3; the fifth group is never read (rd_fifo stays 0 with a non-empty FIFO) until clr, then ram_addr=0 and ram_full=0.
- fifo_empty=1 after 2 samples, held for 10 cycles, then 2 more samples (4, 8, 12, 16):
  - busy=0 during the stall.
  - Single write, ram_data=10.
- clr asserted in ACC of sample 3, then samples 100×4:
  - No write from the aborted group.
  - Next write at address 0 with data 100.
  - Async reset_n pulse mid-group behaves the same and all outputs read 0 during reset.
- LOG2_N=0, samples 7, 9:
  - Two writes, data 7 and 9, at addresses 0 and 1.
  - zero_sel high on every ACC.
